// File: rtl/ext_arb_pkg.sv
// Shared definitions for the extension arbiter: size modes, output-stage
// states and the round-robin pointer step.
package ext_arb_pkg;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Wraps explicitly so non-power-of-two requester counts step correctly.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/ext_mode_unit.sv
// Combinational sub-word extender: byte/half sign- or zero-extension,
// word pass-through (mode 11 aliases word).
module ext_mode_unit
   import ext_arb_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] data_i,
   input  logic [1:0]   mode_i,
   input  logic         sign_i,
   output logic [W-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (mode_i)
         MODE_BYTE: data_o = {{(W-8){sign_i & data_i[7]}}, data_i[7:0]};
         MODE_HALF: data_o = {{(W-16){sign_i & data_i[15]}}, data_i[15:0]};
         default:   data_o = data_i;
      endcase
   end

endmodule

// File: rtl/ext_share_arbiter.sv
// Round-robin arbiter sharing one extension unit among NUM_REQ requesters,
// with a one-entry registered valid/ready output stage.
module ext_share_arbiter
   import ext_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned TARGET_SIZE = 32,
   parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*TARGET_SIZE-1:0] req_data,
   input  logic [NUM_REQ*2-1:0]           req_mode,
   input  logic [NUM_REQ-1:0]             req_sign,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [TARGET_SIZE-1:0]         rsp_data,
   output logic [ID_W-1:0]                rsp_id
);

   out_state_e             state_q, state_d;
   logic [TARGET_SIZE-1:0] data_q, data_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic [ID_W-1:0]        rr_q, rr_d;

   logic                   found;
   logic [ID_W-1:0]        grant;
   logic                   can_accept;
   logic                   xfer;
   logic [TARGET_SIZE-1:0] sel_data;
   logic [1:0]             sel_mode;
   logic                   sel_sign;
   logic [TARGET_SIZE-1:0] ext_data;

   // Rotated priority as two passes: indices at/after rr_q first, then the rest.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (ID_W'(i) >= rr_q)) begin
            found = 1'b1;
            grant = ID_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            grant = ID_W'(i);
         end
      end
   end

   assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
   assign xfer       = found && can_accept;

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = rst_n && xfer && (grant == ID_W'(i));
      end
   end

   always_comb begin
      sel_data = '0;
      sel_mode = '0;
      sel_sign = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_data = req_data[i*TARGET_SIZE +: TARGET_SIZE];
            sel_mode = req_mode[i*2 +: 2];
            sel_sign = req_sign[i];
         end
      end
   end

   ext_mode_unit #(
      .W (TARGET_SIZE)
   ) u_ext (
      .data_i (sel_data),
      .mode_i (sel_mode),
      .sign_i (sel_sign),
      .data_o (ext_data)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      rr_d    = rr_q;
      if (xfer) begin
         state_d = ST_FULL;
         data_d  = ext_data;
         id_d    = grant;
         rr_d    = ID_W'(next_ptr(32'(grant), NUM_REQ));
      end else if ((state_q == ST_FULL) && rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;

endmodule

// File: doc/ext_share_arbiter.md
# ext_share_arbiter

Shares a single sub-word extension datapath between several requesters, for example the ID-stage immediate path and the MEM-stage load-data path. Each requester offers a raw word, a size mode and a sign flag under a valid/ready handshake. The block picks one requester per cycle by round-robin, extends its data to the target width and returns the result with the winner's ID through a one-entry registered output stage with its own valid/ready handshake.

## Interface
- `NUM_REQ`, default 2: number of requesters, ≥2.
- `TARGET_SIZE`, default 32: output width and raw input width, ≥16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_data`, input, `NUM_REQ*TARGET_SIZE`: raw data; requester i occupies slice `[i*TARGET_SIZE +: TARGET_SIZE]`.
- `req_mode`, input, `NUM_REQ*2`: size per requester; 00 byte, 01 half, 10 and 11 word.
- `req_sign`, input, `NUM_REQ`: 1 = sign-extend, 0 = zero-extend.
- `rsp_valid`, output, 1: output register holds a result.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_data`, output, `TARGET_SIZE`: extended result.
- `rsp_id`, output, `ID_W`: index of the requester that produced `rsp_data`.

## Operation
- **Extension.**
  - Byte mode: bits `[7:0]`, filled with bit 7 if sign is 1, else zeros.
  - Half mode: bits `[15:0]`, filled with bit 15 if sign is 1, else zeros.
  - Word mode: data passes through unchanged; sign is ignored. Mode 11 behaves exactly like 10.
- **Accept condition.** `can_accept = !rsp_valid | rsp_ready`.
- **Arbitration.** Combinational round-robin over `req_valid`, starting at pointer `rr_ptr`. The first valid index at or after `rr_ptr` (modulo `NUM_REQ`) wins. `req_ready[w] = can_accept`; all other ready bits are 0.
- **Transfer.** A transfer occurs for requester i when `req_valid[i] & req_ready[i]`. On the next edge:
  - `rsp_data` loads the extended value.
  - `rsp_id` loads i.
  - `rsp_valid` becomes 1.
  - `rr_ptr` becomes (i+1) mod `NUM_REQ`.
- **Drain.** If `rsp_valid & rsp_ready` and there is no new transfer, `rsp_valid` becomes 0. `rsp_data` and `rsp_id` keep their values.
- **Stall.** While `rsp_valid & !rsp_ready`:
  - `rsp_data`, `rsp_id` and `rr_ptr` are frozen.
  - All `req_ready` are 0.
- **Requester rules.** A requester holds valid, data, mode and sign stable until it sees ready. The block must not depend on a requester deasserting valid.
- **States.** The block has two implicit states, EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY goes to FULL on a transfer.
  - FULL stays FULL on a transfer, or while `!rsp_ready`.
  - FULL goes to EMPTY on `rsp_ready` with no transfer.
- **Reset.** Asserting `rst_n` low at any time immediately forces:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rr_ptr`=0.
  - `req_ready`=0 while in reset, and a result in flight is discarded.
  - After release, requester 0 has highest priority.

## Timing
- Latency is 1 cycle from a transfer edge to `rsp_valid` high with the data.
- Throughput is one result per cycle while `rsp_ready` is held high (simultaneous drain and load).
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_data` to any output.
- **Fairness.** With all requesters continuously valid and the consumer always ready, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- **Boundary behaviour.**
  - No `req_valid` set: nothing changes except a possible drain.
  - Pointer wrap: the step from NUM_REQ-1 to 0 is mod `NUM_REQ`, including non-power-of-two `NUM_REQ`.
  - Only one requester valid: it wins regardless of `rr_ptr`, and `rr_ptr` still updates.

## Structure
- Shared package `ext_arb_pkg`:
  - Mode localparams: `MODE_BYTE`=2'b00, `MODE_HALF`=2'b01, `MODE_WORD`=2'b10.
  - Function `next_ptr(ptr, n)`.
- Sub-module `ext_mode_unit` (combinational): inputs data, mode and sign; output is the extended word; instantiated once after the grant mux.
- Top level contains the round-robin grant logic, the grant mux, the output register and `rr_ptr`.

## Test plan
- **Reset values.** Hold `rst_n` low, then release with no requests: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `req_ready`=0.
- **Extension modes.** Requester 0 only, consumer ready:
  - data 0x0000_0080, byte, sign=1: one cycle later `rsp_data`=0xFFFF_FF80, `rsp_id`=0.
  - Same data, sign=0: 0x0000_0080.
  - 0x1234_8001, half, sign=1: 0xFFFF_8001.
  - 0x8000_0000, word, sign=1: 0x8000_0000.
  - Mode 11 with 0x8000_0000: equals the word-mode result.
- **Round-robin.** Both requesters valid every cycle, consumer ready: `rsp_id` sequence 0,1,0,1 on back-to-back cycles with `rsp_valid` continuously 1.
- **Back-pressure.** Hold `rsp_ready`=0 for 3 cycles while FULL:
  - `rsp_data` and `rsp_id` stay stable and all `req_ready` are 0.
  - On `rsp_ready`=1, the next grant goes to the requester after the held `rsp_id`.
- **Reset mid-operation.** Assert `rst_n`=0 asynchronously (mid-cycle) while FULL and stalled: `rsp_valid` drops immediately without waiting for an edge. After release with both requesting, the first grant goes to requester 0.
